// File: rtl/axis_sync_fifo_if.sv
// rtl/axis_sync_fifo_if.sv - AXI-Stream beat bundle shared by both sides of axis_sync_fifo
interface axis_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - first-word-fall-through AXI-Stream FIFO with optional store-and-forward framing
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16,
  parameter int FRAME_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  axis_sync_fifo_if.slave        s_axis,
  axis_sync_fifo_if.master       m_axis,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] frames
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
  logic [USER_WIDTH-1:0] mem_user [DEPTH];
  logic [DEPTH-1:0]      mem_last;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          ready, release_q, valid;
  logic          wr, rd, wr_last, rd_last;
  logic [CW-1:0] count_nxt, frames_nxt;

  assign wr         = s_axis.tvalid & ready;
  assign rd         = valid & m_axis.tready;
  assign wr_last    = wr & s_axis.tlast;
  assign rd_last    = rd & mem_last[rd_ptr];
  assign count_nxt  = count + CW'(wr) - CW'(rd);
  assign frames_nxt = frames + CW'(wr_last) - CW'(rd_last);

  // In frame mode a full FIFO holding no tlast must still drain, hence the release flag.
  always_comb begin
    if (FRAME_MODE == 0) valid = (count != '0);
    else                 valid = (count != '0) && (frames != '0 || count == FULL || release_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frames    <= '0;
      ready     <= 1'b0;
      release_q <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count  <= count_nxt;
      frames <= frames_nxt;
      ready  <= (count_nxt < FULL);
      if (rd_last)                                release_q <= 1'b0;
      else if (count_nxt == FULL && frames_nxt == '0) release_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wr_ptr] <= s_axis.tdata;
      mem_keep[wr_ptr] <= s_axis.tkeep;
      mem_user[wr_ptr] <= s_axis.tuser;
      mem_last[wr_ptr] <= s_axis.tlast;
    end
  end

  assign s_axis.tready = ready;
  assign m_axis.tvalid = valid;
  assign m_axis.tdata  = mem_data[rd_ptr];
  assign m_axis.tkeep  = mem_keep[rd_ptr];
  assign m_axis.tuser  = mem_user[rd_ptr];
  assign m_axis.tlast  = mem_last[rd_ptr];
endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb/tb_axis_sync_fifo.sv - queue-model bench for three axis_sync_fifo configurations
module tb_axis_sync_fifo;
  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic [1:0] u;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       s_valid [3];
  logic       s_last  [3];
  logic       s_keep  [3];
  logic       m_ready [3];
  logic [7:0] s_data  [3];
  logic [1:0] s_user  [3];

  logic [4:0] cnt_o    [3];
  logic [4:0] frm_o    [3];
  logic       s_rdy_o  [3];
  logic       m_vld_o  [3];
  logic       m_lst_o  [3];
  logic       m_keep_o [3];
  logic [7:0] m_dat_o  [3];
  logic [1:0] m_user_o [3];

  int nw   [3];
  int sim2 [3];
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] got [$];

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, g, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Instance 0: DEPTH 16 cut-through, 1: DEPTH 4 cut-through, 2: DEPTH 4 frame mode.
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int DEP = (g == 0) ? 16 : 4;
    localparam int FM  = (g == 2) ? 1 : 0;
    localparam int CW  = $clog2(DEP) + 1;

    logic [CW-1:0] cnt, frm;
    beat_t q [$];
    bit rel = 1'b0;
    bit rdy_m = 1'b0;

    axis_sync_fifo_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(2)) s_if ();
    axis_sync_fifo_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(2)) m_if ();

    assign s_if.tdata  = s_data[g];
    assign s_if.tkeep  = s_keep[g];
    assign s_if.tuser  = s_user[g];
    assign s_if.tvalid = s_valid[g];
    assign s_if.tlast  = s_last[g];
    assign m_if.tready = m_ready[g];
    assign s_rdy_o[g]  = s_if.tready;
    assign m_vld_o[g]  = m_if.tvalid;
    assign m_dat_o[g]  = m_if.tdata;
    assign m_keep_o[g] = m_if.tkeep;
    assign m_user_o[g] = m_if.tuser;
    assign m_lst_o[g]  = m_if.tlast;
    assign cnt_o[g]    = 5'(cnt);
    assign frm_o[g]    = 5'(frm);

    axis_sync_fifo #(
      .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(2), .DEPTH(DEP), .FRAME_MODE(FM)
    ) u_dut (
      .clk(clk), .rstn(rstn), .s_axis(s_if), .m_axis(m_if), .count(cnt), .frames(frm)
    );

    function automatic int nfr();
      int n = 0;
      foreach (q[i]) n += int'(q[i].l);
      return n;
    endfunction

    function automatic bit mv();
      if (q.size() == 0) return 1'b0;
      if (FM == 0) return 1'b1;
      return (nfr() != 0) || (q.size() == DEP) || rel;
    endfunction

    // Inputs change only at negedge+1, so at negedge they still hold what the last posedge sampled.
    initial forever begin
      @(negedge clk);
      if (!rstn) begin
        q.delete();
        rel = 1'b0;
        rdy_m = 1'b0;
      end else begin : upd
        bit wr, rd, rl;
        int pre;
        beat_t b;
        pre = q.size();
        wr = s_valid[g] && rdy_m;
        rd = mv() && m_ready[g];
        rl = rd ? q[0].l : 1'b0;
        if (wr) nw[g]++;
        if (wr && rd && pre == 2) sim2[g]++;
        if (rd) void'(q.pop_front());
        if (wr) begin
          b.d = s_data[g]; b.k = s_keep[g]; b.u = s_user[g]; b.l = s_last[g];
          q.push_back(b);
        end
        if (rl) rel = 1'b0;
        else if (q.size() == DEP && nfr() == 0) rel = 1'b1;
        rdy_m = (q.size() < DEP);
      end
      chk("count", g, 32'(cnt), 32'(q.size()));
      chk("frames", g, 32'(frm), 32'(nfr()));
      chk("s_tready", g, 32'(s_rdy_o[g]), 32'(rdy_m));
      chk("m_tvalid", g, 32'(m_vld_o[g]), 32'(mv()));
      if (mv()) begin
        chk("m_tdata", g, 32'(m_dat_o[g]), 32'(q[0].d));
        chk("m_tkeep", g, 32'(m_keep_o[g]), 32'(q[0].k));
        chk("m_tuser", g, 32'(m_user_o[g]), 32'(q[0].u));
        chk("m_tlast", g, 32'(m_lst_o[g]), 32'(q[0].l));
      end
    end
  end

  task automatic wr_beats(input int g, input logic [7:0] base, input int from, input int to, input int last_at);
    for (int k = from; k <= to; k++) begin
      s_valid[g] = 1'b1;
      s_data[g]  = base + 8'(k);
      s_last[g]  = (k == last_at);
      step();
    end
    s_valid[g] = 1'b0;
    s_last[g]  = 1'b0;
  endtask

  // Keeps writing beats sent0..total-1 (tlast on the final one) while reading total beats.
  task automatic xfer(input int g, input logic [7:0] base, input int total, input int sent0);
    int sent;
    bit acc_w;
    sent = sent0;
    got.delete();
    s_valid[g] = (sent < total);
    s_data[g]  = base + 8'(sent);
    s_last[g]  = (sent == total - 1);
    m_ready[g] = 1'b1;
    for (int c = 0; c < 60 && got.size() < total; c++) begin
      acc_w = s_valid[g] && s_rdy_o[g];
      if (m_vld_o[g]) got.push_back(m_dat_o[g]);
      step();
      if (acc_w) begin
        sent++;
        s_valid[g] = (sent < total);
        s_data[g]  = base + 8'(sent);
        s_last[g]  = (sent == total - 1);
      end
    end
    m_ready[g] = 1'b0;
    s_valid[g] = 1'b0;
    s_last[g]  = 1'b0;
    chk("xfer_n", g, 32'(got.size()), 32'(total));
    for (int i = 0; i < total; i++)
      chk("xfer_order", g, (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(base) + 32'(i));
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      s_valid[g] = 0; s_last[g] = 0; s_keep[g] = 0; m_ready[g] = 0;
      s_data[g] = '0; s_user[g] = '0; nw[g] = 0; sim2[g] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 0, 32'(cnt_o[0]), 32'd0);
    chk("rst_tready", 0, 32'(s_rdy_o[0]), 32'd0);
    chk("rst_tvalid", 0, 32'(m_vld_o[0]), 32'd0);
    rstn = 1'b1;
    step();
    chk("tready_rise", 0, 32'(s_rdy_o[0]), 32'd1);

    // Single beat through the DEPTH 16 instance
    s_valid[0] = 1; s_data[0] = 8'hA5; s_last[0] = 1; s_keep[0] = 1; s_user[0] = 2'd2;
    chk("no_bypass", 0, 32'(m_vld_o[0]), 32'd0);
    step();
    s_valid[0] = 0; s_last[0] = 0;
    chk("one_tvalid", 0, 32'(m_vld_o[0]), 32'd1);
    chk("one_tdata", 0, 32'(m_dat_o[0]), 32'hA5);
    chk("one_tuser", 0, 32'(m_user_o[0]), 32'd2);
    chk("one_count", 0, 32'(cnt_o[0]), 32'd1);
    chk("one_frames", 0, 32'(frm_o[0]), 32'd1);
    m_ready[0] = 1;
    step();
    m_ready[0] = 0;
    chk("one_count_rd", 0, 32'(cnt_o[0]), 32'd0);
    chk("one_tvalid_rd", 0, 32'(m_vld_o[0]), 32'd0);

    // Fill DEPTH 4 with backpressure, then drain six beats in order
    wr_beats(1, 8'h00, 0, 2, -1);
    chk("fill_tready3", 1, 32'(s_rdy_o[1]), 32'd1);
    wr_beats(1, 8'h00, 3, 3, -1);
    chk("full_tready", 1, 32'(s_rdy_o[1]), 32'd0);
    chk("full_count", 1, 32'(cnt_o[1]), 32'd4);
    xfer(1, 8'h00, 6, 4);

    // Frame gating: three-beat frame held back until its tlast is stored
    m_ready[2] = 1;
    wr_beats(2, 8'h10, 0, 1, 2);
    chk("gate_tvalid", 2, 32'(m_vld_o[2]), 32'd0);
    chk("gate_frames0", 2, 32'(frm_o[2]), 32'd0);
    wr_beats(2, 8'h10, 2, 2, 2);
    chk("gate_open", 2, 32'(m_vld_o[2]), 32'd1);
    chk("gate_frames1", 2, 32'(frm_o[2]), 32'd1);
    xfer(2, 8'h10, 3, 3);
    chk("gate_frames_end", 2, 32'(frm_o[2]), 32'd0);

    // Oversize seven-beat frame released at full
    wr_beats(2, 8'h20, 0, 2, 6);
    chk("big_tvalid3", 2, 32'(m_vld_o[2]), 32'd0);
    wr_beats(2, 8'h20, 3, 3, 6);
    chk("big_tvalid4", 2, 32'(m_vld_o[2]), 32'd1);
    chk("big_count4", 2, 32'(cnt_o[2]), 32'd4);
    xfer(2, 8'h20, 7, 4);
    wr_beats(2, 8'h30, 0, 0, -1);
    chk("rel_cleared", 2, 32'(m_vld_o[2]), 32'd0);
    chk("rel_count", 2, 32'(cnt_o[2]), 32'd1);

    // Asynchronous reset with three beats stored
    wr_beats(1, 8'h40, 0, 2, 1);
    chk("pre_rst_count", 1, 32'(cnt_o[1]), 32'd3);
    rstn = 1'b0;
    #1;
    chk("arst_count", 1, 32'(cnt_o[1]), 32'd0);
    chk("arst_frames", 1, 32'(frm_o[1]), 32'd0);
    chk("arst_tvalid", 1, 32'(m_vld_o[1]), 32'd0);
    chk("arst_count2", 2, 32'(cnt_o[2]), 32'd0);
    step();
    rstn = 1'b1;
    step();
    chk("arst_tready", 1, 32'(s_rdy_o[1]), 32'd1);

    // Random traffic with random backpressure on all three instances
    for (int g = 0; g < 3; g++) begin
      nw[g] = 0;
      sim2[g] = 0;
    end
    for (int c = 0; c < 20000; c++) begin
      if (nw[0] >= 1000 && nw[1] >= 1000 && nw[2] >= 1000) break;
      for (int g = 0; g < 3; g++) begin
        s_valid[g] = (g == 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
        s_data[g]  = 8'($urandom);
        s_keep[g]  = 1'($urandom);
        s_user[g]  = 2'($urandom);
        s_last[g]  = ($urandom_range(0, (g == 2) ? 5 : 3) == 0);
        m_ready[g] = (g == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) != 0);
      end
      step();
    end
    for (int g = 0; g < 3; g++) begin
      s_valid[g] = 0;
      m_ready[g] = 1;
      chk("rand_writes", g, 32'(nw[g] >= 1000), 32'd1);
    end
    chk("sim_at_2", 0, 32'(sim2[0] > 0), 32'd1);
    chk("sim_at_2", 1, 32'(sim2[1] > 0), 32'd1);
    repeat (40) step();
    chk("drain_count", 0, 32'(cnt_o[0]), 32'd0);
    chk("drain_count", 1, 32'(cnt_o[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
